// File: rtl/timer_tick_sched_if.sv
// rtl/timer_tick_sched_if.sv - Avalon-MM link between the tick scheduler and the interval timer slave
interface timer_tick_sched_if;
  logic        tmr_irq;
  logic [15:0] tmr_readdata;
  logic [3:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;

  modport master (
    input  tmr_irq,
    input  tmr_readdata,
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata
  );

  modport slave (
    output tmr_irq,
    output tmr_readdata,
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata
  );
endinterface

// File: rtl/timer_tick_sched.sv
// rtl/timer_tick_sched.sv - interval timer service master with divided tick fan-out (optional TIMER_TICK_SCHED_VERIFY_EN)
module timer_tick_sched #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  timer_tick_sched_if.master      tmr,
  input  logic                    enable,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic [31:0]             tick_count,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_DISPATCH,
    S_VERIFY,
    S_VERIFY_CAP
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_cs;
  logic              r_write_n;
  logic [3:0]        r_address;
  logic [15:0]       r_writedata;
  logic              r_busy;
  logic [NUM_CH-1:0] r_ch_tick;
  logic [31:0]       r_tick_count;
  logic [DIV_W-1:0]  r_cnt [NUM_CH];

  logic              w_cs;
  logic              w_write_n;
  logic [3:0]        w_address;
  logic [15:0]       w_writedata;
  logic              w_dispatch;
  logic [DIV_W-1:0]  w_div [NUM_CH];

`ifdef TIMER_TICK_SCHED_VERIFY_EN
  // Readdata lags the read address by one cycle, so VERIFY_CAP spends one
  // cycle with the read on the bus and samples on its second cycle.
  logic              r_cap_phase;
`else
  logic              w_unused_rdata;
  assign w_unused_rdata = ^tmr.tmr_readdata;
`endif

  // Unpack the flat divisor bus into one divisor per channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_div[i] = ch_div[i*DIV_W +: DIV_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef TIMER_TICK_SCHED_VERIFY_EN
  // Toggle through the two VERIFY_CAP cycles; cleared everywhere else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_phase <= 1'b0;
    end else if (r_state == S_VERIFY_CAP) begin
      r_cap_phase <= ~r_cap_phase;
    end else begin
      r_cap_phase <= 1'b0;
    end
  end
`endif

  // Next state and the bus access to launch on the coming cycle.
  always_comb begin
    w_next      = r_state;
    w_cs        = 1'b0;
    w_write_n   = 1'b1;
    w_address   = 4'd0;
    w_writedata = 16'h0000;
    w_dispatch  = 1'b0;
    case (r_state)
      S_INIT: begin
        // Control register: ITO | START.
        w_cs        = 1'b1;
        w_write_n   = 1'b0;
        w_address   = 4'd1;
        w_writedata = 16'h0005;
`ifdef TIMER_TICK_SCHED_VERIFY_EN
        w_next      = S_VERIFY;
`else
        w_next      = S_IDLE;
`endif
      end
      S_IDLE: begin
        if (tmr.tmr_irq) begin
          // Status register write of zero clears TO; lands in the CLR cycle.
          w_cs      = 1'b1;
          w_write_n = 1'b0;
          w_next    = S_CLR;
        end
      end
      S_CLR:      w_next = S_WAIT;
      S_WAIT:     w_next = S_DISPATCH;
      S_DISPATCH: begin
        w_dispatch = enable;
        w_next     = S_IDLE;
      end
`ifdef TIMER_TICK_SCHED_VERIFY_EN
      S_VERIFY: begin
        w_cs   = 1'b1;
        w_next = S_VERIFY_CAP;
      end
      S_VERIFY_CAP: begin
        if (r_cap_phase) begin
          w_next = tmr.tmr_readdata[1] ? S_IDLE : S_INIT;
        end
      end
`endif
      default:    w_next = S_INIT;
    endcase
  end

  // Registered bus outputs and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs        <= 1'b0;
      r_write_n   <= 1'b1;
      r_address   <= 4'd0;
      r_writedata <= 16'h0000;
      r_busy      <= 1'b1;
    end else begin
      r_cs        <= w_cs;
      r_write_n   <= w_write_n;
      r_address   <= w_address;
      r_writedata <= w_writedata;
      r_busy      <= (w_next != S_IDLE);
    end
  end

  // Base tick dispatch: tick counter and per-channel dividers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_tick    <= '0;
      r_tick_count <= 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_ch_tick <= '0;
      if (w_dispatch) begin
        r_tick_count <= r_tick_count + 32'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_div[i] == '0) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] >= w_div[i] - DIV_W'(1)) begin
            // >= rather than == so a divisor lowered below the running
            // count fires on the next tick instead of wrapping around.
            r_ch_tick[i] <= 1'b1;
            r_cnt[i]     <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + DIV_W'(1);
          end
        end
      end
    end
  end

  assign tmr.tmr_chipselect = r_cs;
  assign tmr.tmr_write_n    = r_write_n;
  assign tmr.tmr_address    = r_address;
  assign tmr.tmr_writedata  = r_writedata;
  assign ch_tick            = r_ch_tick;
  assign tick_count         = r_tick_count;
  assign busy               = r_busy;

endmodule

// File: tb/tb_timer_tick_sched.sv
// tb/tb_timer_tick_sched.sv - self-checking bench for timer_tick_sched
module tb_timer_tick_sched;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    enable = 1'b1;
  logic [NUM_CH*DIV_W-1:0] ch_div = '0;
  logic [NUM_CH-1:0]       ch_tick;
  logic [31:0]             tick_count;
  logic                    busy;

  logic                    fire = 1'b0;
  logic                    to_flag = 1'b0;
  logic [15:0]             rdata = 16'h0000;
  int                      rd_idx = 0;
  int                      n_init = 0;
  int                      n_clr = 0;
  int                      n_rd = 0;

  int                      n_cmp = 0;
  int                      n_err = 0;

  timer_tick_sched_if u_if ();

  timer_tick_sched #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tmr        (u_if),
    .enable     (enable),
    .ch_div     (ch_div),
    .ch_tick    (ch_tick),
    .tick_count (tick_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign u_if.tmr_irq      = to_flag;
  assign u_if.tmr_readdata = rdata;

  // Timer slave model: TO set on request, cleared by a status write.
  always @(posedge clk) begin
    if (u_if.tmr_chipselect && !u_if.tmr_write_n && u_if.tmr_address == 4'd0) to_flag <= 1'b0;
    else if (fire) to_flag <= 1'b1;
  end

  // Status reads return RUN=0 first after each reset, RUN=1 afterwards.
  always @(posedge clk) begin
    if (!reset_n) rd_idx <= 0;
    else if (u_if.tmr_chipselect && u_if.tmr_write_n) begin
      rdata  <= (rd_idx == 0) ? 16'h0000 : 16'h0002;
      rd_idx <= rd_idx + 1;
    end
  end

  // Bus access counters.
  always @(posedge clk) begin
    if (u_if.tmr_chipselect) begin
      if (!u_if.tmr_write_n && u_if.tmr_address == 4'd1) n_init <= n_init + 1;
      if (!u_if.tmr_write_n && u_if.tmr_address == 4'd0) n_clr <= n_clr + 1;
      if (u_if.tmr_write_n) n_rd <= n_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_word();
    return {10'd0, u_if.tmr_chipselect, u_if.tmr_write_n, u_if.tmr_address, u_if.tmr_writedata};
  endfunction

  // Expects to be called at a negedge; releases reset and checks the INIT write.
  task automatic bring_up(input string tag);
    int  i0, r0;
    bit  found;
    i0 = n_init;
    r0 = n_rd;
    found = 0;
    reset_n = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (u_if.tmr_chipselect && !u_if.tmr_write_n) found = 1;
    end
    chk({tag, "_init_seen"}, 32'(found), 32'd1);
    chk({tag, "_init_bus"}, bus_word(), {10'd0, 1'b1, 1'b0, 4'd1, 16'h0005});
`ifndef TIMER_TICK_SCHED_VERIFY_EN
    @(negedge clk);
    chk({tag, "_bus_idle"}, bus_word(), {10'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
`endif
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (!busy) found = 1;
      else @(negedge clk);
    end
    chk({tag, "_idle_seen"}, 32'(found), 32'd1);
    chk({tag, "_bus_quiet"}, bus_word(), {10'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
`ifdef TIMER_TICK_SCHED_VERIFY_EN
    chk({tag, "_n_init"}, 32'(n_init - i0), 32'd2);
    chk({tag, "_n_rd"}, 32'(n_rd - r0), 32'd2);
`else
    chk({tag, "_n_init"}, 32'(n_init - i0), 32'd1);
    chk({tag, "_n_rd"}, 32'(n_rd - r0), 32'd0);
`endif
    chk({tag, "_tick_count"}, tick_count, 32'd0);
  endtask

  // One timer timeout serviced end to end, with cycle-exact latency checks.
  task automatic service(input string tag, input logic [3:0] exp_tick, input logic [31:0] exp_cnt);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    chk({tag, "_irq"}, 32'(u_if.tmr_irq), 32'd1);
    @(negedge clk);
    chk({tag, "_clr_bus"}, bus_word(), {10'd0, 1'b1, 1'b0, 4'd0, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_pre_tick"}, 32'(ch_tick), 32'd0);
    @(negedge clk);
    chk({tag, "_tick"}, 32'(ch_tick), 32'(exp_tick));
    chk({tag, "_count"}, tick_count, exp_cnt);
    @(negedge clk);
    chk({tag, "_post_tick"}, 32'(ch_tick), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Reference: with divisors fixed since the last counter reset, channel i
  // fires on the k-th enabled tick exactly when k is a multiple of its divisor.
  function automatic logic [3:0] model_ticks(input int divs[NUM_CH], input int k);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i] = (divs[i] != 0) && (k % divs[i] == 0);
    return r;
  endfunction

  initial begin
    int divs[NUM_CH];
    int k;
    int c0;
    bit en;

    repeat (3) @(negedge clk);
    chk("rst_bus", bus_word(), {10'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ch_tick", 32'(ch_tick), 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);
    bring_up("boot");

    divs = '{1, 2, 3, 0};
    ch_div = {8'd0, 8'd3, 8'd2, 8'd1};
    enable = 1'b1;
    for (k = 1; k <= 6; k++) service($sformatf("div_t%0d", k), model_ticks(divs, k), 32'(k));

    c0 = n_clr;
    enable = 1'b0;
    for (int j = 0; j < 3; j++) service("disabled", 4'b0000, 32'd6);
    chk("disabled_clears", 32'(n_clr - c0), 32'd3);
    enable = 1'b1;
    service("reenable", model_ticks(divs, 7), 32'd7);

    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_bus", bus_word(), {10'd0, 1'b0, 1'b1, 4'd0, 16'h0000});
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ch_tick", 32'(ch_tick), 32'd0);
    chk("midrst_tick_count", tick_count, 32'd0);
    @(negedge clk);
    bring_up("rerun");

    ch_div = {8'd0, 8'd0, 8'd1, 8'd5};
    for (k = 1; k <= 3; k++) service("lower_pre", 4'b0010, 32'(k));
    ch_div = {8'd0, 8'd0, 8'd1, 8'd2};
    service("lower_t4", 4'b0011, 32'd4);
    service("lower_t5", 4'b0010, 32'd5);
    service("lower_t6", 4'b0011, 32'd6);

    reset_n = 1'b0;
    @(negedge clk);
    bring_up("rand");
    for (int i = 0; i < NUM_CH; i++) begin
      divs[i] = int'($urandom_range(0, 6));
      ch_div[i*DIV_W +: DIV_W] = DIV_W'(divs[i]);
    end
    k = 0;
    for (int j = 0; j < 24; j++) begin
      en = 1'($urandom_range(0, 1));
      enable = en;
      if (en) begin
        k++;
        service("rand_on", model_ticks(divs, k), 32'(k));
      end else begin
        service("rand_off", 4'b0000, 32'(k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
